rr_reg_arbiter: RTL and testbench
=================================

Name: rr_reg_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared WIDTH-bit D-flip-flop register with true and complement outputs (q/qb).
- Up to NREQ requesters contend for write access.
- The block grants one owner at a time, performs the owner's writes on posedge clk, and enforces a bounded hold time so no requester starves.
- It sits between client logic and the shared state register.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, register width in bits
- HOLD_MAX, 4, maximum consecutive writes per grant before forced rotation (1..15)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  NREQ  per-requester write request, level, held until granted
- wdata  input  NREQ*WIDTH  flat write data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, registered
- owner  output  $clog2(NREQ)  index of current grantee; valid only when busy=1
- busy  output  1  a grant is active
- q  output  WIDTH  shared register value
- qb  output  WIDTH  bitwise complement of q, registered alongside q

Behaviour:
- Reset (async, rst=1):
  - gnt=0, busy=0, owner=0, q=0, qb=all ones.
  - State=IDLE, rotation pointer ptr=0, hold counter cnt=0.
- States: IDLE, GRANT.
- IDLE, any req set at posedge:
  - Winner = first set req at or after ptr, scanning upward with wrap.
  - Next cycle: gnt=onehot(winner), owner=winner, busy=1, cnt=0, state=GRANT.
  - Grant latency: 1 cycle from req sampled to gnt visible.
  - No write occurs in the IDLE cycle.
- IDLE, req=0: stay in IDLE; outputs hold.
- GRANT, at each posedge with req[owner]=1:
  - q<=wdata[owner], qb<=~wdata[owner]; cnt<=cnt+1.
  - One write per cycle.
- GRANT, req[owner]=0 at posedge:
  - No write.
  - ptr<=owner+1 (mod NREQ).
  - If another req is set: regrant immediately to the next winner (searched from owner+1), cnt=0.
  - Otherwise: IDLE, gnt=0, busy=0.
- Forced rotation: at the posedge performing write number HOLD_MAX:
  - If any other req is set: write completes, ptr<=owner+1, grant passes to the next winner on the following cycle (no idle cycle).
  - If no other req is set: cnt saturates at HOLD_MAX and the owner keeps the grant.
- Wrap: the pointer increments modulo NREQ; owner=NREQ-1 rotates to index 0.
- gnt is always one-hot or zero, never multi-hot.
- Requests from non-owners are ignored for writes; they cause no change to q.
- q/qb change only on a granted write and hold otherwise.
- Reset mid-grant: all state returns to reset values immediately; pending writes are lost.

Optional Feature:
- Macro RR_REG_PARITY_EN.
- Defined:
  - Adds output q_par (1 bit) = even parity (^) of the value written, registered with q.
  - Reset value 0.
  - Updated only on writes.
- Undefined: port absent; no parity logic.

Decomposition:
- Package rr_reg_pkg:
  - State enum {IDLE, GRANT}.
  - Hold-counter width constant CNT_W=4.
  - Reset constants Q_RST=0 and QB_RST=all ones (as functions of WIDTH).
- Sub-module rr_pick:
  - Purely combinational rotating-priority picker.
  - Inputs req and ptr; outputs winner index and any_req.
  - Instantiated once in rr_reg_arbiter.

Test Plan:
- Reset check: assert rst mid-simulation with active grant -> q=8'h00, qb=8'hFF, gnt=0, busy=0 immediately, without waiting for clk.
- Single requester: req=4'b0010, wdata[1]=8'hA5 -> gnt=4'b0010 one cycle later; next edge q=8'hA5, qb=8'h5A; owner=1.
- Rotation fairness: req=4'b1111 held, HOLD_MAX=4 -> grants cycle 0,1,2,3,0, each owner performing exactly 4 writes; no idle cycle between owners.
- Wrap-around: owner=3 releases while req=4'b0101 -> next gnt=4'b0001 (index 0), then index 2.
- Saturating hold: req=4'b0100 alone for 10 cycles -> gnt stays 4'b0100; 10 consecutive writes, all reflected on q.
- Parity (RR_REG_PARITY_EN defined): write 8'h07 -> q_par=1; write 8'h03 -> q_par=0.

Source files
------------

// File: rtl/rr_reg_pkg.sv
// Shared types and constants for the round-robin register arbiter.
package rr_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int CNT_W = 4;

    // Per-bit reset values; replicated to WIDTH at the point of use.
    localparam logic Q_RST_BIT  = 1'b0;
    localparam logic QB_RST_BIT = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, with wrap.
module rr_pick
    import rr_reg_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    always_comb begin
        int j;
        j       = 0;
        winner  = '0;
        any_req = |req;
        // Walk from the farthest offset down so the nearest hit wins last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                winner = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter guarding a shared q/qb register with bounded hold.
// Define RR_REG_PARITY_EN to add the registered even-parity output q_par.
module rr_reg_arbiter
    import rr_reg_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic [WIDTH-1:0]          q,
`ifdef RR_REG_PARITY_EN
    output logic                      q_par,
`endif
    output logic [WIDTH-1:0]          qb
);

    localparam int IW = $clog2(NREQ);
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_MAX);
    localparam logic [WIDTH-1:0] Q_RST  = {WIDTH{Q_RST_BIT}};
    localparam logic [WIDTH-1:0] QB_RST = {WIDTH{QB_RST_BIT}};

    state_t            state, state_n;
    logic [IW-1:0]     ptr, ptr_n, owner_n, owner_inc;
    logic [IW-1:0]     pick_ptr, winner;
    logic [NREQ-1:0]   gnt_n, pick_req, win_oh;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              busy_n, any_req, wr_en;
    logic [WIDTH-1:0]  wr_data;

    assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign wr_data   = wdata[owner*WIDTH +: WIDTH];
    assign win_oh    = NREQ'(1) << winner;

    // While granted, search the other requesters starting after the owner.
    always_comb begin
        pick_req = req;
        pick_ptr = ptr;
        if (state == GRANT) begin
            pick_req = req & ~gnt;
            pick_ptr = owner_inc;
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (pick_req),
        .ptr     (pick_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        gnt_n   = gnt;
        busy_n  = busy;
        cnt_n   = cnt;
        wr_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = GRANT;
                    owner_n = winner;
                    gnt_n   = win_oh;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (req[owner]) begin
                    wr_en = 1'b1;
                    if (cnt >= HOLD - 1'b1 && any_req) begin
                        ptr_n   = owner_inc;
                        owner_n = winner;
                        gnt_n   = win_oh;
                        cnt_n   = '0;
                    end else if (cnt < HOLD) begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    ptr_n = owner_inc;
                    cnt_n = '0;
                    if (any_req) begin
                        owner_n = winner;
                        gnt_n   = win_oh;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            gnt   <= gnt_n;
            busy  <= busy_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= Q_RST;
            qb <= QB_RST;
        end else if (wr_en) begin
            q  <= wr_data;
            qb <= ~wr_data;
        end
    end

`ifdef RR_REG_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_par <= 1'b0;
        end else if (wr_en) begin
            q_par <= ^wr_data;
        end
    end
`endif

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed self-checking bench for rr_reg_arbiter (NREQ=4, WIDTH=8, HOLD_MAX=4).
module tb_rr_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic [7:0]  qb;
`ifdef RR_REG_PARITY_EN
    logic        q_par;
`endif

    int checks = 0;
    int errors = 0;

    rr_reg_arbiter #(
        .NREQ     (4),
        .WIDTH    (8),
        .HOLD_MAX (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .q     (q),
`ifdef RR_REG_PARITY_EN
        .q_par (q_par),
`endif
        .qb    (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        rst   = 1'b1;
        #2;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = '0;
        wdata = '0;
        #3;
        checks++;
        if (q !== 8'h00 || qb !== 8'hFF || gnt !== 4'b0 || busy !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: q=%h qb=%h gnt=%b busy=%b owner=%0d want 00 ff 0000 0 0",
                     q, qb, gnt, busy, owner);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        wdata[15:8] = 8'hA5;
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || busy !== 1'b1 || owner !== 2'd1 || q !== 8'h00) begin
            errors++;
            $display("FAIL single_grant: gnt=%b busy=%b owner=%0d q=%h want 0010 1 1 00",
                     gnt, busy, owner, q);
        end
        tick();
        checks++;
        if (q !== 8'hA5 || qb !== 8'h5A) begin
            errors++;
            $display("FAIL single_write: q=%h qb=%h want a5 5a", q, qb);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || q !== 8'hA5) begin
            errors++;
            $display("FAIL single_release: gnt=%b busy=%b q=%h want 0000 0 a5", gnt, busy, q);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] d [4];
        int         seq [5];
        d   = '{8'h11, 8'h22, 8'h33, 8'h44};
        seq = '{0, 1, 2, 3, 0};
        do_reset();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req   = 4'b1111;
        tick();
        for (int s = 0; s < 5; s++) begin
            for (int w = 0; w < 4; w++) begin
                checks++;
                if (gnt !== (4'b0001 << seq[s]) || owner !== 2'(seq[s]) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rotation_gnt: slot %0d write %0d gnt=%b owner=%0d want owner %0d",
                             s, w, gnt, owner, seq[s]);
                end
                tick();
                checks++;
                if (q !== d[seq[s]] || qb !== ~d[seq[s]]) begin
                    errors++;
                    $display("FAIL rotation_q: slot %0d write %0d q=%h want %h", s, w, q, d[seq[s]]);
                end
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req   = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || owner !== 2'd3) begin
            errors++;
            $display("FAIL wrap_first: gnt=%b owner=%0d want 1000 3", gnt, owner);
        end
        req = 4'b0101;
        tick();
        checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0 || q !== 8'h00) begin
            errors++;
            $display("FAIL wrap_to_zero: gnt=%b owner=%0d q=%h want 0001 0 00", gnt, owner, q);
        end
        tick();
        checks++;
        if (q !== 8'hA0) begin
            errors++;
            $display("FAIL wrap_write0: q=%h want a0", q);
        end
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || owner !== 2'd2 || q !== 8'hA0) begin
            errors++;
            $display("FAIL wrap_next2: gnt=%b owner=%0d q=%h want 0100 2 a0", gnt, owner, q);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        wdata = {8'hEE, 8'h00, 8'hEE, 8'hEE};
        req   = 4'b0100;
        tick();
        for (int k = 0; k < 10; k++) begin
            wdata[23:16] = 8'h30 + 8'(k);
            tick();
            checks++;
            if (gnt !== 4'b0100 || q !== 8'h30 + 8'(k)) begin
                errors++;
                $display("FAIL saturate: write %0d gnt=%b q=%h want 0100 %h", k, gnt, q, 8'h30 + 8'(k));
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        wdata[7:0] = 8'hC3;
        req = 4'b0001;
        tick();
        tick();
        checks++;
        if (q !== 8'hC3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: q=%h busy=%b want c3 1", q, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (q !== 8'h00 || qb !== 8'hFF || gnt !== 4'b0 || busy !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL midrst_async: q=%h qb=%h gnt=%b busy=%b owner=%0d want 00 ff 0000 0 0",
                     q, qb, gnt, busy, owner);
        end
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

`ifdef RR_REG_PARITY_EN
    task automatic test_parity();
        do_reset();
        checks++;
        if (q_par !== 1'b0) begin
            errors++;
            $display("FAIL parity_reset: q_par=%b want 0", q_par);
        end
        wdata[7:0] = 8'h07;
        req = 4'b0001;
        tick();
        tick();
        checks++;
        if (q_par !== 1'b1) begin
            errors++;
            $display("FAIL parity_07: q_par=%b want 1", q_par);
        end
        wdata[7:0] = 8'h03;
        tick();
        checks++;
        if (q_par !== 1'b0) begin
            errors++;
            $display("FAIL parity_03: q_par=%b want 0", q_par);
        end
        req = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_saturate();
        test_reset_mid();
`ifdef RR_REG_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
